scaler_to_ddr: RTL
==================

# scaler_to_ddr

Output-side bridge for the bicubic scaler. It takes processed pixels from the scaler output port, buffers them in a synchronous FIFO, and throttles the scaler through `nextDout`. It then drains the pixels as length-bounded write bursts to the DDR write port and signals `scaler_done` once every pixel of the output frame has been written.

## Interface
- `DATA_W`, 24: pixel width (RGB888).
- `FIFO_AW`, 9: FIFO address width; depth is 2^FIFO_AW = 512.
- `BURST_LEN`, 64: maximum beats per DDR burst (1..127).
- `SLACK`, 8: free FIFO entries reserved for scaler pipeline latency after `nextDout` falls.
- `ADDR_W`, 28: DDR pixel address width.
- `BASE_ADDR`, 0: frame base address.

Ports:
- `clk`  in  1: scaler clock; all logic in this domain.
- `rst`  in  1: reset, asynchronous, active-high.
- `outpix_x`  in  11: output line width in pixels (1..2047). Static during a frame.
- `outpix_y`  in  11: output lines per frame (1..2047). Static during a frame.
- `frame_start`  in  1: one-cycle pulse; begins a new frame (driven from the scaler `start`).
- `dOutValid`  in  1: scaler output pixel valid.
- `postRGB`  in  DATA_W: scaler output pixel.
- `nextDout`  out  1: scaler output enable (backpressure).
- `ddr_wr_req`  out  1: burst request.
- `ddr_wr_gnt`  in  1: burst grant, one-cycle pulse.
- `ddr_wr_addr`  out  ADDR_W: burst start address; stable while `ddr_wr_req` is high.
- `ddr_wr_len`  out  7: burst beat count; stable while `ddr_wr_req` is high.
- `ddr_wr_en`  out  1: data beat valid.
- `ddr_wr_data`  out  DATA_W: beat data.
- `ddr_wr_rdy`  in  1: DDR accepts the beat.
- `scaler_done`  out  1: one-cycle pulse when the frame is fully written.
- `overflow`  out  1: sticky flag; FIFO write attempted while full.

## Operation
- Frame total `TOT = outpix_x * outpix_y` (22 bits) is registered on `frame_start`.
- Counters are 22 bits: `in_cnt` counts accepted pixels and `out_cnt` counts written beats.
- A pixel is accepted when `dOutValid` is high and `in_cnt < TOT`. Pixels beyond `TOT` are dropped.
- A write while the FIFO is full drops the pixel and sets `overflow`. Only `rst` clears `overflow`.
- `nextDout` is registered. It is high when `fifo_count <= DEPTH - SLACK` and the frame is active, otherwise low.
- FSM states and transitions:
  - `IDLE`: waits for `frame_start`, then goes to `WAIT`.
  - `WAIT`: computes `rem = TOT - out_cnt` and `len = min(BURST_LEN, rem)`. Goes to `REQ` when `fifo_count >= len` and `rem > 0`. Goes to `DONE` when `rem == 0`.
  - `REQ`: `ddr_wr_req=1`, `ddr_wr_addr = BASE_ADDR + out_cnt`, `ddr_wr_len = len`. On `ddr_wr_gnt`, goes to `DATA`.
  - `DATA`: `ddr_wr_en=1`. Each beat where `ddr_wr_en & ddr_wr_rdy` pops the FIFO and increments `out_cnt` and the beat counter. After `len` beats, returns to `WAIT`.
  - `DONE`: pulses `scaler_done` for one cycle, then goes to `IDLE`.
- `frame_start` in any state:
  - flushes the FIFO and clears both counters;
  - reloads `TOT`;
  - aborts any burst in progress (`ddr_wr_req` and `ddr_wr_en` drop the next cycle);
  - enters `WAIT`.
- When `frame_start` and `dOutValid` occur in the same cycle, the flush wins and the pixel is discarded.

## Timing
- Reset values:
  - `nextDout=0`, `ddr_wr_req=0`, `ddr_wr_en=0`;
  - `ddr_wr_addr=0`, `ddr_wr_len=0`, `ddr_wr_data=0`;
  - `scaler_done=0`, `overflow=0`;
  - FSM in `IDLE`.
- The FIFO is first-word-fall-through: `ddr_wr_data` shows the FIFO head combinationally in `DATA`.
- Write to read latency: a pixel accepted at edge N is counted in `fifo_count` at N+1.
- `nextDout` lags `fifo_count` by 1 cycle. `SLACK` covers this lag plus the scaler pipeline.
- `REQ` to first beat: the cycle after `ddr_wr_gnt`.
- `ddr_wr_rdy` may deassert mid-burst. `ddr_wr_en` and `ddr_wr_data` then hold until the beat is accepted.
- A simultaneous FIFO push and pop leaves `fifo_count` unchanged.
- `scaler_done` is asserted the cycle after the final beat is accepted.

## Structure
- Shared package `scaler_pkg`:
  - FSM state enum (`IDLE`, `WAIT`, `REQ`, `DATA`, `DONE`);
  - `PIX_CNT_W = 22`;
  - `DIM_W = 11`;
  - RGB width constant.
- One sub-module, `scaler_out_fifo`:
  - synchronous, first-word-fall-through;
  - depth 2^FIFO_AW;
  - outputs `count`, `full`, `empty`;
  - synchronous `flush` input.
- Top level holds the counters, the FSM and the `nextDout` logic.

## Test plan
- 4x2 frame, continuous `dOutValid`, `ddr_wr_rdy`=1, grant after 3 cycles, `BURST_LEN`=64 → one burst with `addr=0`, `len=8`; beats carry pixels in input order; `scaler_done` asserted the cycle after beat 8.
- 100x2 frame (`TOT`=200) → bursts of len 64, 64, 64, 8 at addr 0, 64, 128, 192; then `scaler_done`.
- Grant withheld, scaler streaming → `nextDout` falls once `fifo_count` exceeds 504; `fifo_count` peaks at 512 or less; `overflow` stays 0.
- `ddr_wr_rdy` toggling 1/0 every cycle during a burst → no beat lost or duplicated; `ddr_wr_data` held while `ddr_wr_rdy`=0.
- `frame_start` mid-burst after 10 beats → `ddr_wr_en` low next cycle; FIFO empty; next burst at `BASE_ADDR`.
- Force `dOutValid` high with `nextDout` ignored and no grant → `overflow`=1 and stays set until `rst`.

Source files
------------

// File: rtl/scaler_pkg.sv
// ---------------------------------------------------------------------------
// scaler_pkg
// Shared definitions for the scaler output-to-DDR bridge.
//   PIX_CNT_W : width of pixel counters and frame total (2047*2047 fits)
//   DIM_W     : width of the frame dimension inputs
//   RGB_W     : packed RGB888 pixel width
//   LEN_W     : width of the DDR burst length field
//   state_t   : burst controller state encoding
// ---------------------------------------------------------------------------
package scaler_pkg;
   localparam int PIX_CNT_W = 22;
   localparam int DIM_W     = 11;
   localparam int RGB_W     = 24;
   localparam int LEN_W     = 7;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      REQ,
      DATA,
      DONE
   } state_t;
endpackage

// File: rtl/scaler_out_fifo.sv
// ---------------------------------------------------------------------------
// scaler_out_fifo
// Synchronous first-word-fall-through FIFO, depth 2**AW.
//   clk, rst       : clock, asynchronous active-high reset
//   flush          : synchronous clear of all contents (wins over push/pop)
//   wr_en, wr_data : push request; ignored while full
//   rd_en          : pop request; ignored while empty
//   rd_data        : current head, valid whenever empty is low
//   count          : number of stored entries (0..2**AW)
//   full, empty    : status flags derived from count
// ---------------------------------------------------------------------------
module scaler_out_fifo
   import scaler_pkg::*;
#(
   parameter int DATA_W = RGB_W,
   parameter int AW     = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic [AW:0]       count,
   output logic              full,
   output logic              empty
);
   localparam int DEPTH = 1 << AW;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic              w_push;
   logic              w_pop;

   assign full  = (r_count == (AW+1)'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;

   assign w_push = wr_en & ~full  & ~flush;
   assign w_pop  = rd_en & ~empty & ~flush;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   // Head is read combinationally so the consumer sees data without a read cycle.
   assign rd_data = r_mem[r_rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/scaler_to_ddr.sv
// ---------------------------------------------------------------------------
// scaler_to_ddr
// Buffers scaler output pixels and writes them to DDR as bounded bursts.
//   clk, rst                 : clock, asynchronous active-high reset
//   outpix_x, outpix_y       : output frame dimensions, sampled on frame_start
//   frame_start              : starts (or restarts) a frame, flushing all state
//   dOutValid, postRGB       : scaler pixel stream
//   nextDout                 : backpressure to the scaler
//   ddr_wr_req/gnt/addr/len  : burst request handshake
//   ddr_wr_en/data/rdy       : burst data beats
//   scaler_done              : one-cycle pulse when the whole frame is written
//   overflow                 : sticky, a pixel arrived while the FIFO was full
// ---------------------------------------------------------------------------
module scaler_to_ddr
   import scaler_pkg::*;
#(
   parameter int                DATA_W    = RGB_W,
   parameter int                FIFO_AW   = 9,
   parameter int                BURST_LEN = 64,
   parameter int                SLACK     = 8,
   parameter int                ADDR_W    = 28,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIM_W-1:0]  outpix_x,
   input  logic [DIM_W-1:0]  outpix_y,
   input  logic              frame_start,
   input  logic              dOutValid,
   input  logic [DATA_W-1:0] postRGB,
   output logic              nextDout,
   output logic              ddr_wr_req,
   input  logic              ddr_wr_gnt,
   output logic [ADDR_W-1:0] ddr_wr_addr,
   output logic [LEN_W-1:0]  ddr_wr_len,
   output logic              ddr_wr_en,
   output logic [DATA_W-1:0] ddr_wr_data,
   input  logic              ddr_wr_rdy,
   output logic              scaler_done,
   output logic              overflow
);
   localparam int                DEPTH       = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]  NEXT_THRESH = (FIFO_AW+1)'(DEPTH - SLACK);
   localparam logic [LEN_W-1:0]  MAX_LEN     = LEN_W'(BURST_LEN);

   state_t               r_state;
   logic [PIX_CNT_W-1:0] r_tot;
   logic [PIX_CNT_W-1:0] r_in_cnt;
   logic [PIX_CNT_W-1:0] r_out_cnt;
   logic [LEN_W-1:0]     r_len;
   logic [LEN_W-1:0]     r_beat;
   logic [ADDR_W-1:0]    r_addr;
   logic                 r_req;
   logic                 r_en;
   logic                 r_done;
   logic                 r_next_dout;
   logic                 r_overflow;

   logic [PIX_CNT_W-1:0] w_rem;
   logic [LEN_W-1:0]     w_len;
   logic [FIFO_AW:0]     w_fifo_count;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [DATA_W-1:0]    w_fifo_head;
   logic                 w_accept;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_active;

   // frame_start flushes the FIFO, so a pixel arriving in that cycle is discarded.
   assign w_accept = dOutValid & ~frame_start & (r_in_cnt < r_tot);
   assign w_push   = w_accept & ~w_fifo_full;
   assign w_pop    = r_en & ddr_wr_rdy & ~w_fifo_empty;
   assign w_rem    = r_tot - r_out_cnt;
   assign w_len    = (w_rem < PIX_CNT_W'(BURST_LEN)) ? w_rem[LEN_W-1:0] : MAX_LEN;
   assign w_active = (r_state != IDLE);

   scaler_out_fifo #(
      .DATA_W (DATA_W),
      .AW     (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (frame_start),
      .wr_en   (w_accept),
      .wr_data (postRGB),
      .rd_en   (w_pop),
      .rd_data (w_fifo_head),
      .count   (w_fifo_count),
      .full    (w_fifo_full),
      .empty   (w_fifo_empty)
   );

   // Input side: frame total, accepted-pixel count, backpressure, overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tot       <= '0;
         r_in_cnt    <= '0;
         r_next_dout <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_overflow  <= r_overflow | (w_accept & w_fifo_full);
         r_next_dout <= w_active & (w_fifo_count <= NEXT_THRESH);
         if (frame_start) begin
            r_tot    <= PIX_CNT_W'(outpix_x) * PIX_CNT_W'(outpix_y);
            r_in_cnt <= '0;
         end else if (w_push) begin
            r_in_cnt <= r_in_cnt + 1'b1;
         end
      end
   end

   // Burst controller. The final beat jumps straight to DONE so scaler_done
   // is high in the cycle right after that beat is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_out_cnt <= '0;
         r_beat    <= '0;
         r_len     <= '0;
         r_addr    <= '0;
         r_req     <= 1'b0;
         r_en      <= 1'b0;
         r_done    <= 1'b0;
      end else if (frame_start) begin
         r_state   <= WAIT;
         r_out_cnt <= '0;
         r_beat    <= '0;
         r_req     <= 1'b0;
         r_en      <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
            end
            WAIT: begin
               if (w_rem == '0) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end else if (w_fifo_count >= (FIFO_AW+1)'(w_len)) begin
                  r_state <= REQ;
                  r_req   <= 1'b1;
                  r_addr  <= BASE_ADDR + ADDR_W'(r_out_cnt);
                  r_len   <= w_len;
               end
            end
            REQ: begin
               if (ddr_wr_gnt) begin
                  r_state <= DATA;
                  r_req   <= 1'b0;
                  r_en    <= 1'b1;
                  r_beat  <= '0;
               end
            end
            DATA: begin
               if (w_pop) begin
                  r_out_cnt <= r_out_cnt + 1'b1;
                  r_beat    <= r_beat + 1'b1;
                  if (r_beat + 1'b1 == r_len) begin
                     r_en <= 1'b0;
                     if (r_out_cnt + 1'b1 == r_tot) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= WAIT;
                     end
                  end
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign nextDout    = r_next_dout;
   assign ddr_wr_req  = r_req;
   assign ddr_wr_addr = r_addr;
   assign ddr_wr_len  = r_len;
   assign ddr_wr_en   = r_en;
   assign ddr_wr_data = r_en ? w_fifo_head : '0;
   assign scaler_done = r_done;
   assign overflow    = r_overflow;
endmodule
